// File: rtl/bp_fe_lce_resp_arb_pkg.sv
// Shared types for the FE LCE response arbiter.
// Source ids select which producer's response is written into the output FIFO.
package bp_fe_lce_resp_arb_pkg;

  typedef enum logic {
    e_resp_src_req = 1'b0,
    e_resp_src_cmd = 1'b1
  } bp_fe_resp_src_e;

endpackage

// File: rtl/bp_fe_lce_resp_fifo.sv
// Two-entry ready/valid FIFO that buffers granted LCE responses.
// The head is always driven straight from storage, so it holds steady while ready is low.
module bp_fe_lce_resp_fifo #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] i_data,
  input  logic               i_valid,
  output logic [width_p-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [1:0]         o_count
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  // The writer only offers data when it has already seen room; no bypass on dequeue.
  assign w_enq   = i_valid & (r_count != 2'd2);
  assign w_deq   = (r_count != 2'd0) & i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq) begin
        r_rptr <= ~r_rptr;
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_le_2: assert property (@(posedge clk_i) disable iff (!reset_n_i) r_count <= 2'd2);

endmodule

// File: rtl/bp_fe_lce_resp_arb.sv
// LCE response arbiter: picks the miss-request or command producer each cycle with
// starvation-bounded fixed priority, buffers grants in a 2-entry FIFO, and reports idle for mode switches.
module bp_fe_lce_resp_arb
  import bp_fe_lce_resp_arb_pkg::*;
#(
  parameter  int resp_width_p        = 64,
  parameter  int starve_limit_p      = 4,
  localparam int starve_cnt_width_lp = $clog2(starve_limit_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [resp_width_p-1:0] req_resp_i,
  input  logic                    req_resp_v_i,
  output logic                    req_resp_yumi_o,
  input  logic [resp_width_p-1:0] cmd_resp_i,
  input  logic                    cmd_resp_v_i,
  output logic                    cmd_resp_yumi_o,
  output logic [resp_width_p-1:0] lce_resp_o,
  output logic                    lce_resp_v_o,
  input  logic                    lce_resp_ready_i,
  input  logic                    quiesce_i,
  output logic                    idle_o,
  output logic                    starved_o
);

  localparam logic [starve_cnt_width_lp-1:0] starve_max_lp = starve_cnt_width_lp'(starve_limit_p);

  logic [starve_cnt_width_lp-1:0] r_starve_cnt;
  logic [1:0]                     w_fifo_count;
  logic                           w_can_grant;
  logic                           w_grant_v;
  bp_fe_resp_src_e                w_grant_src;
  logic [resp_width_p-1:0]        w_grant_data;

  assign starved_o = (r_starve_cnt == starve_max_lp);

  // Gating with reset keeps both yumis low while the block is held in reset.
  assign w_can_grant = reset_n_i & ~quiesce_i & (w_fifo_count != 2'd2);

  always_comb begin
    w_grant_v   = 1'b0;
    w_grant_src = e_resp_src_req;
    if (w_can_grant) begin
      if (starved_o && cmd_resp_v_i) begin
        w_grant_v   = 1'b1;
        w_grant_src = e_resp_src_cmd;
      end else if (req_resp_v_i) begin
        w_grant_v   = 1'b1;
        w_grant_src = e_resp_src_req;
      end else if (cmd_resp_v_i) begin
        w_grant_v   = 1'b1;
        w_grant_src = e_resp_src_cmd;
      end
    end
  end

  assign req_resp_yumi_o = w_grant_v & (w_grant_src == e_resp_src_req);
  assign cmd_resp_yumi_o = w_grant_v & (w_grant_src == e_resp_src_cmd);
  assign w_grant_data    = (w_grant_src == e_resp_src_cmd) ? cmd_resp_i : req_resp_i;
  assign idle_o          = (w_fifo_count == 2'd0) & ~req_resp_yumi_o & ~cmd_resp_yumi_o;

  // Counter only moves when cmd actually loses to req; quiesce/full stalls leave it untouched.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_starve_cnt <= '0;
    end else if (cmd_resp_yumi_o || !cmd_resp_v_i) begin
      r_starve_cnt <= '0;
    end else if (req_resp_yumi_o) begin
      r_starve_cnt <= starved_o ? r_starve_cnt : r_starve_cnt + 1'b1;
    end
  end

  bp_fe_lce_resp_fifo #(
    .width_p (resp_width_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_data    (w_grant_data),
    .i_valid   (w_grant_v),
    .o_data    (lce_resp_o),
    .o_valid   (lce_resp_v_o),
    .i_ready   (lce_resp_ready_i),
    .o_count   (w_fifo_count)
  );

  a_req_yumi_has_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    req_resp_yumi_o |-> req_resp_v_i);
  a_cmd_yumi_has_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    cmd_resp_yumi_o |-> cmd_resp_v_i);
  a_one_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(req_resp_yumi_o && cmd_resp_yumi_o));
  a_req_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (req_resp_v_i && !req_resp_yumi_o) |=> $stable(req_resp_i));
  a_cmd_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (cmd_resp_v_i && !cmd_resp_yumi_o) |=> $stable(cmd_resp_i));

endmodule

// File: doc/bp_fe_lce_resp_arb.md
Name: bp_fe_lce_resp_arb

Overview:
Arbiter and output buffer for the I-cache LCE response channel. Two producers share it: the miss-request path (transfer and writeback responses) and the command path (sync and invalidate acks). The block grants one producer per cycle with starvation-bounded fixed priority and holds granted responses in a 2-entry FIFO. It sits between the FE LCE sub-units and the LCE-CCE response network, and adds a quiesce/idle handshake used when the I-cache mode changes.

Parameters:
resp_width_p, 64, width of one packed LCE response (set to lce_cce_resp_width_lp at instantiation)
starve_limit_p, 4, consecutive lost cycles after which the command path takes priority (>=1)
starve_cnt_width_lp, $clog2(starve_limit_p+1), localparam, starvation counter width

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
req_resp_i  in  resp_width_p  response from the miss-request path
req_resp_v_i  in  1  req_resp_i valid
req_resp_yumi_o  out  1  req_resp_i consumed this cycle
cmd_resp_i  in  resp_width_p  response from the command path
cmd_resp_v_i  in  1  cmd_resp_i valid
cmd_resp_yumi_o  out  1  cmd_resp_i consumed this cycle
lce_resp_o  out  resp_width_p  head of FIFO
lce_resp_v_o  out  1  FIFO non-empty
lce_resp_ready_i  in  1  network accepts head
quiesce_i  in  1  block new grants; FIFO keeps draining
idle_o  out  1  FIFO empty and no grant this cycle
starved_o  out  1  command-priority mode active (debug/perf)

Behaviour:
- Reset (asynchronous assert, synchronous-release assumed upstream): FIFO count=0, read/write pointers=0, entries=0, starvation counter=0. Outputs: lce_resp_v_o=0, lce_resp_o=0, yumi outputs=0, starved_o=0, idle_o=1.
- Input protocol is valid-then-yumi. A source holds its data stable while valid until it sees yumi. Yumi never asserts without valid. At most one yumi per cycle.
- can_grant = ~quiesce_i & (count < 2). There is no same-cycle bypass of a dequeue into a full FIFO, so there is no combinational path from lce_resp_ready_i to the yumi outputs.
- Priority: starved_o = (starve_cnt == starve_limit_p).
  - When starved_o=0, the req path wins if it is valid; otherwise cmd wins.
  - When starved_o=1, cmd wins if it is valid.
- Starvation counter, evaluated in order:
  - Clear to 0 when cmd_resp_yumi_o=1 or cmd_resp_v_i=0.
  - Otherwise, if cmd_resp_v_i=1 and cmd loses to req: increment, saturating at starve_limit_p.
  - Hold while cmd is blocked only by ~can_grant.
- Enqueue: the granted source's data is written at wptr, wptr toggles, count increments.
- Dequeue: when lce_resp_v_o & lce_resp_ready_i, rptr toggles and count decrements.
- Simultaneous enqueue and dequeue leaves count unchanged.
- Latency: a response granted in cycle N is visible on lce_resp_o in cycle N+1. Full throughput of 1 response/cycle is sustained when ready stays high.
- lce_resp_o is stable while lce_resp_v_o=1 and ready=0.
- quiesce_i asserted mid-stream: no new yumi from that cycle on. Queued entries drain normally. The starvation counter holds.
- idle_o = (count==0) & ~req_resp_yumi_o & ~cmd_resp_yumi_o. Software and mode logic may switch icache_mode only while quiesce_i=1 and idle_o=1.
- Reset asserted mid-operation: FIFO contents are discarded immediately, lce_resp_v_o drops asynchronously, and no partial entry remains.
- Assertions:
  - no yumi without valid;
  - req_resp_yumi_o & cmd_resp_yumi_o never both set;
  - count <= 2;
  - source data stable while valid and not yumi'd.

Decomposition:
- No new package types; the response struct comes from the existing LCE-CCE interface macros, and resp_width_p is its width.
- Add a package enum for source id (e_resp_src_req=0, e_resp_src_cmd=1), used for the grant select and debug.
- One natural sub-module, bp_fe_lce_resp_fifo: 2-entry ready/valid FIFO with async active-low reset.
- Arbitration and starvation logic stay in the top module.

Test Plan:
- Reset with both sources valid: idle_o=1, v_o=0. After release, req_resp_yumi_o=1 in the first cycle, and lce_resp_o equals req data next cycle.
- Only cmd valid (data 0xA5), ready=1: cmd_resp_yumi_o=1 at cycle N, lce_resp_v_o=1 with 0xA5 at N+1, idle_o=1 at N+2.
- Both valid continuously, ready=1, starve_limit_p=4: req granted 4 cycles (counter 1..4), starved_o=1, cmd granted on the 5th cycle, counter back to 0, pattern repeats 4:1.
- ready=0 with req streaming 0x1,0x2,0x3: two yumis then stall. Output holds 0x1. After ready=1 the order is 0x1,0x2,0x3 with no loss or duplication.
- FIFO holds 2 entries, quiesce_i=1: no yumi. Two entries drain with ready=1. idle_o=1 after the second dequeue. Deassert quiesce and grants resume next cycle.
- reset_n_i pulsed low mid-cycle with 2 entries queued: lce_resp_v_o=0 before the next clock edge. After release, the first grant is fresh data only.
